// File: rtl/efuse_pgm_verify_seq.sv
// Program-and-verify sequencer for the efuse controller: pre-read, burn missing bits,
// verify and retry. Optional macro EFUSE_VFY_MARGIN_EN selects margin sense during verify.
module efuse_pgm_verify_seq #(
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_W           = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_data,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_timeout,
  output logic [3:0]  attempts,
  output logic        write,
  output logic        read,
  output logic        margin_read,
  output logic [31:0] data_write,
  input  logic        wr_done,
  input  logic        rd_done,
  input  logic [31:0] data_read,
  output logic [2:0]  state_dbg
);

  // Request side: a transfer happens on the cycle where req_valid & req_ready; req_ready is
  // high only in IDLE, so req_valid/req_data are don't-care while a sequence is running.
  // Controller side: read/write stay high until rd_done/wr_done is sampled (or timeout).
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE_RD = 3'd1,
    S_PGM    = 3'd2,
    S_VFY_RD = 3'd3,
    S_CHECK  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t          state, state_d;
  logic [31:0]     tgt;
  logic [31:0]     rd_q;
  logic [TO_W-1:0] to_cnt;
  logic [4:0]      pgm_cnt;
  logic [31:0]     miss_pre, miss_chk;
  logic            to_hit, retry_ok, waiting;
  logic            accept, ld_pre, ld_chk, set_pass, set_to, inc_att, cap_rd;

  assign miss_pre = tgt & ~data_read;
  assign miss_chk = tgt & ~rd_q;
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // pgm_cnt is wider than attempts so MAX_RETRY=15 still terminates after 16 burns
  assign retry_ok = (32'(pgm_cnt) <= MAX_RETRY);
  assign waiting  = (state == S_PRE_RD) || (state == S_PGM) || (state == S_VFY_RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    ld_pre   = 1'b0;
    ld_chk   = 1'b0;
    set_pass = 1'b0;
    set_to   = 1'b0;
    inc_att  = 1'b0;
    cap_rd   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_PRE_RD;
        end
      end
      S_PRE_RD: begin
        if (rd_done) begin
          if (miss_pre == 32'd0) begin
            set_pass = 1'b1;
            state_d  = S_FIN;
          end else begin
            ld_pre  = 1'b1;
            state_d = S_PGM;
          end
        end else if (to_hit) begin
          set_to  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_PGM: begin
        if (wr_done) begin
          inc_att = 1'b1;
          state_d = S_VFY_RD;
        end else if (to_hit) begin
          set_to  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_VFY_RD: begin
        if (rd_done) begin
          cap_rd  = 1'b1;
          state_d = S_CHECK;
        end else if (to_hit) begin
          set_to  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_CHECK: begin
        if (miss_chk == 32'd0) begin
          set_pass = 1'b1;
          state_d  = S_FIN;
        end else if (retry_ok) begin
          ld_chk  = 1'b1;
          state_d = S_PGM;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free at the controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read        <= 1'b0;
      write       <= 1'b0;
      margin_read <= 1'b0;
    end else begin
      read  <= (state_d == S_PRE_RD) || (state_d == S_VFY_RD);
      write <= (state_d == S_PGM);
`ifdef EFUSE_VFY_MARGIN_EN
      margin_read <= (state_d == S_VFY_RD);
`else
      margin_read <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state_d != state) begin
      to_cnt <= '0;
    end else if (waiting) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt          <= 32'd0;
      rd_q         <= 32'd0;
      data_write   <= 32'd0;
      attempts     <= 4'd0;
      pgm_cnt      <= 5'd0;
      pass         <= 1'b0;
      fail_timeout <= 1'b0;
    end else begin
      if (accept) begin
        tgt          <= req_data;
        attempts     <= 4'd0;
        pgm_cnt      <= 5'd0;
        pass         <= 1'b0;
        fail_timeout <= 1'b0;
      end
      if (ld_pre) data_write <= miss_pre;
      if (ld_chk) data_write <= miss_chk;
      if (cap_rd) rd_q <= data_read;
      if (inc_att) begin
        pgm_cnt <= pgm_cnt + 5'd1;
        if (attempts != 4'hF) attempts <= attempts + 4'd1;
      end
      if (set_pass) pass <= 1'b1;
      if (set_to) begin
        pass         <= 1'b0;
        fail_timeout <= 1'b1;
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign state_dbg = state;

endmodule
